// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: drives the instruction-memory address from the PC,
// tracks the one-cycle synchronous read, tags each returned word with its PC,
// and queues it toward decode. Stalls the PC when the queue would overflow and
// discards every wrong-path fetch when a jump is taken.
module if_fetch_buffer #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              fetch_busy,
  input  logic              flush,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [INST_W-1:0] instMem_q [DEPTH];
  logic [ADDR_W-1:0] pcMem_q   [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflightPc_q, inflightPc_d;

  logic              notEmpty;
  logic              push;
  logic              pop;
  logic              issue;
  logic [CNT_W:0]    occupancy;

  // The memory address is simply the current PC; the read returns next cycle.
  assign imem_addr = pc_in;

  // Handshake, stall and head-of-queue view; a flush masks everything so no
  // pop, push or issue happens in a jump cycle.
  always_comb begin
    notEmpty   = (count_q != '0);
    id_valid   = notEmpty && !flush;
    pop        = id_valid && id_ready;
    push       = inflight_q && !flush;
    occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    fetch_busy = !flush && (occupancy >= DEPTH_OCC);
    issue      = !fetch_busy && !flush;
    id_inst    = notEmpty ? instMem_q[rdPtr_q] : '0;
    id_pc      = notEmpty ? pcMem_q[rdPtr_q]   : '0;
  end

  // Next-state for pointers, occupancy and the outstanding-read tracker.
  always_comb begin
    count_d      = count_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    inflight_d   = issue;
    inflightPc_d = issue ? pc_in : inflightPc_q;
    if (flush) begin
      count_d = '0;
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state clears asynchronously so the outputs drop without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
    end else begin
      count_q      <= count_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
    end
  end

  // Queue storage captures the returned word tagged with its PC; contents are
  // only meaningful below count, so they are never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instMem_q[wrPtr_q] <= imem_rdata;
      pcMem_q[wrPtr_q]   <= inflightPc_q;
    end
  end

endmodule
